// File: rtl/ad9363_rx_ramp_checker.sv
// AD9363 RX loopback ramp checker: locks on the I ramp and counts mismatches.
// Define RX_CHK_Q_EN to also require Q == ~I on every checked sample.
module ad9363_rx_ramp_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        chk_en,
    input  logic        clr,
    input  logic        rx_status,
    input  logic        adc_valid,
    input  logic [11:0] adc_data_i0,
    input  logic [11:0] adc_data_q0,
    output logic        locked,
    output logic        lock_lost,
    output logic [31:0] sample_cnt,
    output logic [31:0] err_cnt,
    output logic [11:0] last_err_i
);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

    state_t      state_q, state_d;
    logic [11:0] exp_i_q, exp_i_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic        locked_q, locked_d;
    logic        lock_lost_q, lock_lost_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [11:0] last_err_i_q, last_err_i_d;
    logic        active;
    logic        match;

    assign active = chk_en & rx_status;

`ifdef RX_CHK_Q_EN
    assign match = (adc_data_i0 == exp_i_q) && (adc_data_q0 == ~exp_i_q);
`else
    logic unused_q;
    assign unused_q = ^adc_data_q0;
    assign match    = (adc_data_i0 == exp_i_q);
`endif

    always_comb begin
        state_d      = state_q;
        exp_i_d      = exp_i_q;
        run_d        = run_q;
        bad_run_d    = bad_run_q;
        locked_d     = locked_q;
        lock_lost_d  = lock_lost_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        last_err_i_d = last_err_i_q;

        // clr is applied first so a coincident lock loss can still set lock_lost
        if (clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            lock_lost_d  = 1'b0;
        end

        if (!active) begin
            state_d   = IDLE;
            run_d     = '0;
            bad_run_d = '0;
            locked_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = SEARCH;
                    run_d     = '0;
                    bad_run_d = '0;
                end
                SEARCH: begin
                    if (adc_valid) begin
                        exp_i_d = adc_data_i0 + 12'd1;
                        run_d   = (match && run_q != '0) ? run_q + 8'd1 : 8'd1;
                        if (run_d == LOCK_N) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            bad_run_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (adc_valid) begin
                        exp_i_d = exp_i_q + 12'd1;
                        if (!clr && sample_cnt_q != '1)
                            sample_cnt_d = sample_cnt_q + 32'd1;
                        if (match) begin
                            bad_run_d = '0;
                        end else begin
                            if (!clr) begin
                                if (err_cnt_q != '1)
                                    err_cnt_d = err_cnt_q + 32'd1;
                                last_err_i_d = adc_data_i0;
                            end
                            bad_run_d = bad_run_q + 8'd1;
                            if (bad_run_d == LOSS_N) begin
                                state_d     = SEARCH;
                                locked_d    = 1'b0;
                                lock_lost_d = 1'b1;
                                run_d       = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_i_q      <= '0;
            run_q        <= '0;
            bad_run_q    <= '0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            last_err_i_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_i_q      <= exp_i_d;
            run_q        <= run_d;
            bad_run_q    <= bad_run_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            last_err_i_q <= last_err_i_d;
        end
    end

    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign last_err_i = last_err_i_q;

endmodule
